// File: rtl/traffic_intersection_ctrl_if.sv
// ============================================================================
// Module      : traffic_intersection_ctrl_if
// Description : Timebase, request and lamp-drive bundle for the intersection controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface traffic_intersection_ctrl_if;
    logic       tick;
    logic       ped_req;
    logic       flash_en;
    logic       ns_red;
    logic       ns_yellow;
    logic       ns_green;
    logic       ew_red;
    logic       ew_yellow;
    logic       ew_green;
    logic       walk;
    logic       ped_pending;
    logic [2:0] state_o;

    modport master (
        output tick, ped_req, flash_en,
        input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
        input  walk, ped_pending, state_o
    );

    modport slave (
        input  tick, ped_req, flash_en,
        output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
        output walk, ped_pending, state_o
    );
endinterface

`default_nettype wire

// File: rtl/traffic_intersection_ctrl.sv
// ============================================================================
// Module      : traffic_intersection_ctrl
// Description : NS/EW signal controller with all-red clearance, pedestrian walk and flash mode.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module traffic_intersection_ctrl #(
    parameter int CNT_W       = 8,
    parameter int GREEN_T     = 60,
    parameter int MIN_GREEN_T = 10,
    parameter int YELLOW_T    = 5,
    parameter int ALLRED_T    = 2,
    parameter int WALK_T      = 15,
    parameter int FLASH_T     = 8
) (
    input  wire logic clk,
    input  wire logic reset,
    traffic_intersection_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_AR_A  = 3'd0,
        S_NS_G  = 3'd1,
        S_NS_Y  = 3'd2,
        S_AR_B  = 3'd3,
        S_EW_G  = 3'd4,
        S_EW_Y  = 3'd5,
        S_WALK  = 3'd6,
        S_FLASH = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] c_green_last  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] c_min_last    = CNT_W'(MIN_GREEN_T - 1);
    localparam logic [CNT_W-1:0] c_yellow_last = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] c_allred_last = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] c_walk_last   = CNT_W'(WALK_T - 1);
    localparam logic [CNT_W-1:0] c_flash_last  = CNT_W'(FLASH_T - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ped_q, ped_d;
    logic             side_q, side_d;      // 1: walk is followed by EW green
    logic             phase_q, phase_d;
    logic [2:0]       ns_q, ew_q;          // {red, yellow, green}
    logic             walk_q;
    logic             w_ped_now;

    assign w_ped_now = ped_q | (bus.ped_req & (state_q != S_WALK));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ped_d   = ped_q;
        side_d  = side_q;
        phase_d = phase_q;
        if (bus.tick) begin
            ped_d   = w_ped_now;
            count_d = count_q + CNT_W'(1);
            case (state_q)
                S_AR_A, S_AR_B: begin
                    if (count_q == c_allred_last) begin
                        if (bus.flash_en) begin
                            state_d = S_FLASH;
                        end else if (w_ped_now) begin
                            state_d = S_WALK;
                            side_d  = (state_q == S_AR_B);
                        end else if (state_q == S_AR_A) begin
                            state_d = S_NS_G;
                        end else begin
                            state_d = S_EW_G;
                        end
                    end
                end
                S_NS_G: if (count_q == c_green_last || (w_ped_now && count_q >= c_min_last)) state_d = S_NS_Y;
                S_EW_G: if (count_q == c_green_last || (w_ped_now && count_q >= c_min_last)) state_d = S_EW_Y;
                S_NS_Y: if (count_q == c_yellow_last) state_d = S_AR_B;
                S_EW_Y: if (count_q == c_yellow_last) state_d = S_AR_A;
                S_WALK: begin
                    if (count_q == c_walk_last) begin
                        if (side_q) state_d = S_EW_G;
                        else        state_d = S_NS_G;
                    end
                end
                S_FLASH: begin
                    if (!bus.flash_en) begin
                        state_d = S_AR_A;
                    end else if (count_q == c_flash_last) begin
                        count_d = '0;
                        phase_d = ~phase_q;
                    end
                end
                default: state_d = S_AR_A;
            endcase
            if (state_d != state_q) begin
                count_d = '0;
                if (state_d == S_WALK)  ped_d   = 1'b0;
                if (state_d == S_FLASH) phase_d = 1'b1;
            end
        end
    end

    // Lamps are decoded from the next state so they change on the same edge as state_q.
    function automatic logic [6:0] lamp_decode(input state_t s, input logic ph);
        logic [2:0] ns;
        logic [2:0] ew;
        ns = 3'b100;
        ew = 3'b100;
        case (s)
            S_NS_G:  ns = 3'b001;
            S_NS_Y:  ns = 3'b010;
            S_EW_G:  ew = 3'b001;
            S_EW_Y:  ew = 3'b010;
            S_FLASH: begin
                ns = {1'b0, ph, 1'b0};
                ew = {1'b0, ph, 1'b0};
            end
            default: ;
        endcase
        return {ns, ew, (s == S_WALK)};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_AR_A;
            count_q <= '0;
            ped_q   <= 1'b0;
            side_q  <= 1'b0;
            phase_q <= 1'b1;
            ns_q    <= 3'b100;
            ew_q    <= 3'b100;
            walk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ped_q   <= ped_d;
            side_q  <= side_d;
            phase_q <= phase_d;
            {ns_q, ew_q, walk_q} <= lamp_decode(state_d, phase_d);
        end
    end

    assign bus.ns_red      = ns_q[2];
    assign bus.ns_yellow   = ns_q[1];
    assign bus.ns_green    = ns_q[0];
    assign bus.ew_red      = ew_q[2];
    assign bus.ew_yellow   = ew_q[1];
    assign bus.ew_green    = ew_q[0];
    assign bus.walk        = walk_q;
    assign bus.ped_pending = ped_q;
    assign bus.state_o     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_intersection_ctrl.sv
// ============================================================================
// Module      : tb_traffic_intersection_ctrl
// Description : Directed and randomized checks against a remaining-time reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_traffic_intersection_ctrl;

    localparam int GREEN_T     = 6;
    localparam int MIN_GREEN_T = 3;
    localparam int YELLOW_T    = 2;
    localparam int ALLRED_T    = 1;
    localparam int WALK_T      = 3;
    localparam int FLASH_T     = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    traffic_intersection_ctrl_if bus ();

    traffic_intersection_ctrl #(
        .CNT_W       (8),
        .GREEN_T     (GREEN_T),
        .MIN_GREEN_T (MIN_GREEN_T),
        .YELLOW_T    (YELLOW_T),
        .ALLRED_T    (ALLRED_T),
        .WALK_T      (WALK_T),
        .FLASH_T     (FLASH_T)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: phase number, ticks still to run in it, latched request.
    int m_st;
    int m_left;
    bit m_ped;
    bit m_phase;
    int m_walk_to;

    function automatic int dur(input int s);
        case (s)
            0, 3:    return ALLRED_T;
            1, 4:    return GREEN_T;
            2, 5:    return YELLOW_T;
            6:       return WALK_T;
            default: return FLASH_T;
        endcase
    endfunction

    task automatic m_reset();
        m_st = 0; m_left = ALLRED_T; m_ped = 1'b0; m_phase = 1'b1; m_walk_to = 1;
    endtask

    task automatic m_enter(input int s);
        m_st = s;
        m_left = dur(s);
        if (s == 6) m_ped = 1'b0;
        if (s == 7) m_phase = 1'b1;
    endtask

    task automatic m_tick(input bit p, input bit f);
        bit pn;
        bit done;
        pn    = m_ped || (p && m_st != 6);
        m_ped = pn;
        done  = (m_left == 1);
        case (m_st)
            0, 3: begin
                if (!done) m_left--;
                else if (f) m_enter(7);
                else if (pn) begin
                    m_walk_to = (m_st == 0) ? 1 : 4;
                    m_enter(6);
                end else m_enter(m_st + 1);
            end
            1, 4: begin
                if (done || (pn && (dur(m_st) - m_left + 1) >= MIN_GREEN_T)) m_enter(m_st + 1);
                else m_left--;
            end
            2:  if (done) m_enter(3); else m_left--;
            5:  if (done) m_enter(0); else m_left--;
            6:  if (done) m_enter(m_walk_to); else m_left--;
            default: begin
                if (!f) m_enter(0);
                else if (done) begin
                    m_left  = FLASH_T;
                    m_phase = !m_phase;
                end else m_left--;
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [2:0] e_ns;
        logic [2:0] e_ew;
        e_ns = (m_st == 1) ? 3'b001 : (m_st == 2) ? 3'b010 : (m_st == 7) ? {1'b0, m_phase, 1'b0} : 3'b100;
        e_ew = (m_st == 4) ? 3'b001 : (m_st == 5) ? 3'b010 : (m_st == 7) ? {1'b0, m_phase, 1'b0} : 3'b100;
        chk("state", {5'd0, bus.state_o}, 8'(m_st));
        chk("ns_lamps", {5'd0, bus.ns_red, bus.ns_yellow, bus.ns_green}, {5'd0, e_ns});
        chk("ew_lamps", {5'd0, bus.ew_red, bus.ew_yellow, bus.ew_green}, {5'd0, e_ew});
        chk("walk", {7'd0, bus.walk}, {7'd0, m_st == 6});
        chk("ped_pending", {7'd0, bus.ped_pending}, {7'd0, m_ped});
    endtask

    // Called at posedge+1: drive inputs, take one edge, update model, compare.
    task automatic step(input bit t, input bit p, input bit f);
        bus.tick = t; bus.ped_req = p; bus.flash_en = f;
        @(posedge clk);
        if (t) m_tick(p, f);
        #1;
        check_all();
    endtask

    task automatic wait_state(input int target, input int budget);
        int n;
        n = 0;
        while (m_st != target && n < budget) begin
            step(1'b1, 1'b0, 1'b0);
            n++;
        end
        n_assert++;
        assert (m_st == target) else begin
            n_fail++;
            $error("FAIL wait_state observed=%0d expected=%0d", m_st, target);
        end
    endtask

    initial begin
        bus.tick = 1'b0; bus.ped_req = 1'b0; bus.flash_en = 1'b0;
        m_reset();
        #12;
        check_all();
        @(posedge clk); #1;
        reset = 1'b0;

        // Idle ring with a continuous tick.
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0);

        // Request early in green: minimum green honoured, then walk, then EW green.
        wait_state(1, 40);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0);

        // Late request ends green at once; request held through walk is not relatched.
        wait_state(1, 40);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);

        // Flash request during NS green, then release.
        wait_state(1, 40);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);

        // Sparse timebase: one tick in four, requests arriving off-tick too.
        for (int i = 0; i < 240; i++) step((i % 4) == 3, ($urandom_range(0, 15) == 0), 1'b0);

        // Randomized mix of tick gaps, requests and flash bursts.
        begin
            bit fl;
            fl = 1'b0;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 59) == 0) fl = !fl;
                step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, fl);
            end
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);

        // Asynchronous reset in EW green with a pending request.
        wait_state(4, 60);
        step(1'b1, 1'b1, 1'b0);
        chk("pre_reset_ped", {7'd0, bus.ped_pending}, 8'd1);
        #2;
        reset = 1'b1;
        #1;
        m_reset();
        check_all();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
